// File: rtl/lstm_seq_buffer.sv
// Captures one upstream hidden-state sequence, then replays it in order
// to the downstream unit as a load/x stream.
module lstm_seq_buffer #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 301,
    parameter int AW    = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    done_in,
    input  logic                    output_done_in,
    input  logic signed [WIDTH-1:0] a_in,
    output logic                    load_out,
    output logic signed [WIDTH-1:0] x_out,
    output logic [AW-1:0]           seq_len,
    output logic                    overflow,
    output logic                    replay_done
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        GAP,
        REPLAY,
        FIN
    } state_t;

    state_t           state_q;
    logic [AW-1:0]    len_q;
    logic [AW-1:0]    rd_ptr_q;
    logic             load_q;
    logic [WIDTH-1:0] x_q;
    logic             ovf_q;
    logic             rdone_q;

    logic [WIDTH-1:0] mem [DEPTH];

    logic valid;
    logic full;
    logic wr_en;

    assign valid = done_in && !output_done_in;
    assign full  = (len_q == AW'(DEPTH));
    // In IDLE len_q is always zero, so both write cases use len_q as address
    assign wr_en = valid && ((state_q == IDLE) ||
                             (state_q == CAPTURE && !full));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[len_q] <= a_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            rd_ptr_q <= '0;
            load_q   <= 1'b0;
            x_q      <= '0;
            ovf_q    <= 1'b0;
            rdone_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid) begin
                        len_q   <= AW'(1);
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (!valid) begin
                        state_q <= GAP;
                    end else if (full) begin
                        ovf_q <= 1'b1;
                    end else begin
                        len_q <= len_q + AW'(1);
                    end
                end
                GAP: begin
                    rd_ptr_q <= '0;
                    state_q  <= REPLAY;
                end
                REPLAY: begin
                    // One extra REPLAY cycle retires the stream into FIN outputs
                    if (rd_ptr_q == len_q) begin
                        load_q  <= 1'b0;
                        x_q     <= '0;
                        rdone_q <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        load_q   <= 1'b1;
                        x_q      <= mem[rd_ptr_q];
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                    end
                end
                FIN: begin
                    if (!done_in) begin
                        len_q   <= '0;
                        rdone_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign load_out    = load_q;
    assign x_out       = x_q;
    assign seq_len     = len_q;
    assign overflow    = ovf_q;
    assign replay_done = rdone_q;

endmodule

// File: tb/tb_lstm_seq_buffer.sv
// Directed and randomized bench for lstm_seq_buffer against a queue-based
// model of capture, truncation at DEPTH and in-order replay.
module tb_lstm_seq_buffer;

    localparam int WIDTH = 10;
    localparam int DEPTH = 301;
    localparam int AW    = 9;

    logic             clk = 1'b0;
    logic             reset;
    logic             done_in;
    logic             output_done_in;
    logic [WIDTH-1:0] a_in;
    logic             load_out;
    logic [WIDTH-1:0] x_out;
    logic [AW-1:0]    seq_len;
    logic             overflow;
    logic             replay_done;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] stim[$];
    logic [WIDTH-1:0] exp_q[$];
    bit               exp_ovf;

    lstm_seq_buffer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .done_in       (done_in),
        .output_done_in(output_done_in),
        .a_in          (a_in),
        .load_out      (load_out),
        .x_out         (x_out),
        .seq_len       (seq_len),
        .overflow      (overflow),
        .replay_done   (replay_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Capture stim, end the sequence, and follow the replay.
    // abort_at >= 0 asserts reset right after that replay sample is seen.
    task automatic run(input int abort_at, input bit noise);
        exp_q = {};
        foreach (stim[i]) begin
            done_in        = 1'b1;
            output_done_in = 1'b0;
            a_in           = stim[i];
            step();
            if (exp_q.size() < DEPTH) exp_q.push_back(stim[i]);
            else exp_ovf = 1'b1;
            check("cap_len", 32'(seq_len), 32'(exp_q.size()));
            check("cap_ovf", 32'(overflow), 32'(exp_ovf));
        end
        output_done_in = 1'b1;
        step();
        check("gap0_load", 32'(load_out), 0);
        check("gap0_len", 32'(seq_len), 32'(exp_q.size()));
        step();
        check("gap1_load", 32'(load_out), 0);
        check("gap1_x", 32'(x_out), 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (noise) begin
                done_in        = 1'b1;
                output_done_in = 1'b0;
                a_in           = WIDTH'($urandom);
            end
            step();
            check("rep_load", 32'(load_out), 1);
            check("rep_x", 32'(x_out), 32'(exp_q[i]));
            if (i == abort_at) begin
                reset = 1'b1;
                step();
                reset   = 1'b0;
                exp_ovf = 1'b0;
                check("rst_load", 32'(load_out), 0);
                check("rst_x", 32'(x_out), 0);
                check("rst_len", 32'(seq_len), 0);
                check("rst_rdone", 32'(replay_done), 0);
                check("rst_ovf", 32'(overflow), 0);
                return;
            end
        end
        step();
        check("fin_load", 32'(load_out), 0);
        check("fin_x", 32'(x_out), 0);
        check("fin_rdone", 32'(replay_done), 1);
        check("fin_ovf", 32'(overflow), 32'(exp_ovf));
        check("fin_len", 32'(seq_len), 32'(exp_q.size()));
        // Valid samples in FIN are ignored and do not leave FIN
        done_in        = 1'b1;
        output_done_in = 1'b0;
        a_in           = WIDTH'($urandom);
        step();
        check("fin_hold", 32'(replay_done), 1);
        check("fin_hold_ovf", 32'(overflow), 32'(exp_ovf));
        check("fin_hold_load", 32'(load_out), 0);
        done_in = 1'b0;
        step();
        check("idle_rdone", 32'(replay_done), 0);
        check("idle_len", 32'(seq_len), 0);
        check("idle_ovf", 32'(overflow), 32'(exp_ovf));
    endtask

    initial begin
        reset          = 1'b1;
        done_in        = 1'b0;
        output_done_in = 1'b0;
        a_in           = '0;
        exp_ovf        = 1'b0;
        step();
        step();
        check("reset_load", 32'(load_out), 0);
        check("reset_x", 32'(x_out), 0);
        check("reset_len", 32'(seq_len), 0);
        check("reset_ovf", 32'(overflow), 0);
        check("reset_rdone", 32'(replay_done), 0);
        reset = 1'b0;
        step();
        check("idle_quiet", 32'(seq_len), 0);

        stim = {10'h387, 10'h381, 10'h307, 10'h043,
                10'h002, 10'h026, 10'h3E1, 10'h342};
        run(-1, 1'b0);

        stim = {10'h1FF};
        run(-1, 1'b0);

        stim = {};
        for (int i = 0; i < DEPTH; i++) stim.push_back(WIDTH'(i));
        run(-1, 1'b0);

        stim = {};
        for (int i = 1; i <= DEPTH + 4; i++) stim.push_back(WIDTH'(i));
        run(-1, 1'b0);

        stim = {};
        for (int i = 0; i < 8; i++) stim.push_back(WIDTH'($urandom));
        run(2, 1'b0);

        stim = {};
        for (int i = 0; i < 2; i++) stim.push_back(WIDTH'($urandom));
        run(-1, 1'b0);

        stim = {};
        for (int i = 0; i < 5; i++) stim.push_back(WIDTH'($urandom));
        run(-1, 1'b1);

        stim = {};
        for (int i = 0; i < 3; i++) stim.push_back(WIDTH'($urandom));
        run(-1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            stim = {};
            for (int i = 0; i < int'($urandom_range(1, 20)); i++) begin
                stim.push_back(WIDTH'($urandom));
            end
            run(-1, r[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lstm_seq_buffer.md
LSTM_SEQ_BUFFER -- requirements
Module: lstm_seq_buffer

Interface
REQ-001 Parameter: WIDTH, 10, signed fixed-point sample width of a_in/x_out.
REQ-002 Parameter: DEPTH, 301, maximum stored timesteps.
REQ-003 Parameter: AW, 9, address/count width; SHALL satisfy 2^AW > DEPTH.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 done_in  input  1  upstream unit result-valid level (unit done).
REQ-007 output_done_in  input  1  upstream unit end-of-sequence flag.
REQ-008 a_in  input  WIDTH  signed upstream hidden-state sample (a_next).
REQ-009 load_out  output  1  downstream unit load level; high while x_out carries a replayed sample.
REQ-010 x_out  output  WIDTH  signed replayed sample to downstream input_x.
REQ-011 seq_len  output  AW  number of samples captured in the current sequence.
REQ-012 overflow  output  1  sticky flag: a valid sample arrived with the buffer full.
REQ-013 replay_done  output  1  level: replay of the full sequence has completed.

Function
REQ-014 States SHALL be IDLE, CAPTURE, GAP, REPLAY and FIN; all outputs SHALL be registered.
REQ-015 Valid sample = done_in=1 and output_done_in=0, sampled on the rising clk edge.
REQ-016 IDLE: a valid sample SHALL be written to mem[0], seq_len SHALL become 1, and the state SHALL move to CAPTURE on the same edge.
REQ-017 CAPTURE: each valid sample SHALL be written to mem[seq_len] and seq_len incremented by 1; there SHALL be no gap cycles and no backpressure.
REQ-018 CAPTURE with seq_len=DEPTH and a valid sample: the sample SHALL be dropped, seq_len SHALL hold at DEPTH, and overflow SHALL be set to 1 until reset.
REQ-019 CAPTURE: output_done_in=1, or done_in=0, SHALL end capture, with the state moving to GAP on the next edge; the sample present on that edge SHALL NOT be stored.
REQ-020 GAP: lasts exactly one cycle with load_out=0, then the state SHALL move to REPLAY with rd_ptr=0.
REQ-021 REPLAY: each cycle SHALL drive load_out=1 and x_out=mem[rd_ptr], then increment rd_ptr; the first replayed sample SHALL appear 2 clocks after the edge at which end of capture was sampled.
REQ-022 REPLAY SHALL drive exactly seq_len consecutive samples in capture order, then move to FIN.
REQ-023 FIN: load_out=0, x_out=0, replay_done=1.
REQ-024 FIN SHALL return to IDLE on the first edge with done_in=0, clearing replay_done and seq_len.
REQ-025 Valid samples arriving in GAP, REPLAY or FIN SHALL be ignored, with no write and no overflow.
REQ-026 x_out SHALL be bit-exact with the stored a_in; no arithmetic, rounding or sign change is permitted.
REQ-027 x_out SHALL be 0 whenever load_out=0.

Reset
REQ-028 When reset=1 at a rising edge, the state SHALL go to IDLE.
REQ-029 On that same edge, load_out=0, x_out=0, seq_len=0, overflow=0, replay_done=0 and rd_ptr=0.
REQ-030 Memory contents need not be cleared.
REQ-031 Reset SHALL take priority over every other event, including mid-CAPTURE and mid-REPLAY.
REQ-032 On the first edge after reset deasserts, a valid sample SHALL be capturable.

Verification
REQ-033 Basic: 8 valid samples 0x387, 0x381, 0x307, 0x043, 0x002, 0x026, 0x3E1, 0x342, then output_done_in=1 -> seq_len=8; load_out high for exactly 8 cycles starting 2 clocks after output_done_in is sampled; x_out sequence identical to the inputs; then replay_done=1.
REQ-034 Full: 301 valid samples (value = index mod 1024), then end -> seq_len=301, overflow=0, 301 replayed samples in order.
REQ-035 Overflow: 305 valid samples -> seq_len=301, overflow=1; replay yields samples 1..301 only, and overflow stays 1 through FIN.
REQ-036 Reset mid-operation: reset asserted at replay sample 3 of 8 -> next edge load_out=0, x_out=0, seq_len=0, replay_done=0; a new 2-sample sequence then captures and replays correctly.
REQ-037 Ignore and restart: valid samples driven during REPLAY do not alter the replayed data; in FIN, done_in=0 for 1 cycle -> IDLE; a fresh 3-sample sequence then replays with seq_len=3.
REQ-038 Single sample: 1 valid sample 0x1FF, then output_done_in=1 -> load_out high for 1 cycle with x_out=0x1FF, then replay_done=1.
